prbs_checker: RTL

- Receive-side counterpart of the LFSR pseudorandom generator: consumes the serial PRBS bit stream and self-synchronises a local LFSR to it.
- After lock, predicts every incoming bit, flags and counts bit errors, and drops lock when the error density is too high.
- Sits at the far end of the generator's serial output. Bits arrive at the slow divided rate, qualified by a one-cycle strobe in the fast clock domain.

---
 rtl/prbs_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
`timescale 1ns/1ps
// Self-synchronising PRBS receiver: seeds a local LFSR from the stream, then free-runs and counts errors.
// Defining PRBS_BITCNT_EN adds the 32-bit bit_count output and counter.
module prbs_checker #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter int               LOCK_CNT    = 16,
  parameter int               WINDOW      = 64,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef PRBS_BITCNT_EN
  output logic [31:0]      bit_count,
`endif
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WB = $clog2(WINDOW);
  localparam int WE = $clog2(LOSS_THRESH + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lfsr, w_lfsr_nxt;
  logic [MW-1:0]    r_match, w_match_nxt;
  logic [WB-1:0]    r_win_bits, w_win_bits_nxt;
  logic [WE-1:0]    r_win_err, w_win_err_nxt;
  logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
  logic             r_locked, r_err_pulse, w_err_pulse_nxt;
  logic             w_pred, w_mis;
`ifdef PRBS_BITCNT_EN
  logic [31:0]      r_bit_count, w_bit_count_nxt;
`endif

  assign w_pred = ^(r_lfsr & TAPS);
  assign w_mis  = bit_in ^ w_pred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_lfsr      <= '0;
      r_match     <= '0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
      r_err_count <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
`ifdef PRBS_BITCNT_EN
      r_bit_count <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_match     <= w_match_nxt;
      r_win_bits  <= w_win_bits_nxt;
      r_win_err   <= w_win_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_err_pulse <= w_err_pulse_nxt;
`ifdef PRBS_BITCNT_EN
      r_bit_count <= w_bit_count_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lfsr_nxt      = r_lfsr;
    w_match_nxt     = r_match;
    w_win_bits_nxt  = r_win_bits;
    w_win_err_nxt   = r_win_err;
    w_err_count_nxt = r_err_count;
    w_err_pulse_nxt = 1'b0;
`ifdef PRBS_BITCNT_EN
    w_bit_count_nxt = r_bit_count;
`endif
    if (bit_valid) begin
      if (r_state == HUNT) begin
        w_lfsr_nxt = {r_lfsr[WIDTH-2:0], bit_in};
        // A prediction from an all-zero register proves nothing, so it never counts.
        if (!w_mis && (r_lfsr != '0)) begin
          w_match_nxt = r_match + 1'b1;
          if (r_match == MW'(LOCK_CNT - 1)) begin
            w_state_nxt    = LOCKED;
            w_match_nxt    = '0;
            w_win_bits_nxt = '0;
            w_win_err_nxt  = '0;
          end
        end else begin
          w_match_nxt = '0;
        end
      end else begin
        w_lfsr_nxt     = {r_lfsr[WIDTH-2:0], w_pred};
        w_win_bits_nxt = r_win_bits + 1'b1;
`ifdef PRBS_BITCNT_EN
        if (r_bit_count != '1) w_bit_count_nxt = r_bit_count + 1'b1;
`endif
        if (w_mis) begin
          w_err_pulse_nxt = 1'b1;
          w_win_err_nxt   = r_win_err + 1'b1;
          if (r_err_count != '1) w_err_count_nxt = r_err_count + 1'b1;
        end
        // Reaching the threshold beats a window wrap on the same bit.
        if (w_mis && (r_win_err == WE'(LOSS_THRESH - 1))) begin
          w_state_nxt    = HUNT;
          w_match_nxt    = '0;
          w_win_bits_nxt = '0;
          w_win_err_nxt  = '0;
        end else if (r_win_bits == WB'(WINDOW - 1)) begin
          w_win_bits_nxt = '0;
          w_win_err_nxt  = '0;
        end
      end
    end
    if (clr_cnt) begin
      w_err_count_nxt = '0;
`ifdef PRBS_BITCNT_EN
      w_bit_count_nxt = '0;
`endif
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
`ifdef PRBS_BITCNT_EN
  assign bit_count = r_bit_count;
`endif

endmodule
